avr_io_intc: RTL
================

Name: avr_io_intc

Overview:
- Parametrised interrupt controller for the AVR SoC. It replaces the fixed 4-line combinational priority encoder.
- Supports up to 8 IRQ sources, each with:
  - a per-channel enable;
  - a per-channel mode: level, or rising-edge latched into a pending bit.
- Adds a global enable and an automatic clear of the pending bit on core interrupt acknowledge.
- Sits on the I/O bus as a 4-register peripheral. Drives iflag/ivect into avr_core.

Parameters:
- N_IRQ, 4, number of IRQ inputs (1..8); bit 0 has the highest priority.
- VECT_WIDTH, 2, width of ivect and ieack; must satisfy 2^VECT_WIDTH >= N_IRQ.
- RST_MODE, 8'h00, reset value of the MODE register (1 = edge, 0 = level).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- io_re  in  1  read strobe; already qualified by this block's address select.
- io_we  in  1  write strobe; already qualified by this block's address select.
- io_a  in  2  register address.
- io_do  in  8  write data from the core.
- io_dout  out  8  read data; 0 when io_re is low (wor-safe).
- irq  in  N_IRQ  raw interrupt requests, synchronous to clk.
- ieack_stb  in  1  one-cycle pulse: the core has accepted an interrupt.
- ieack  in  VECT_WIDTH  vector being acknowledged; valid while ieack_stb is high.
- iflag  out  1  registered interrupt request to the core.
- ivect  out  VECT_WIDTH  registered index of the highest-priority active channel.

Behaviour:
- Register map (io_a):
  - 0 IER: enable mask, R/W, bits >= N_IRQ read 0.
  - 1 IPR: pending, R; write 1 clears the bit (W1C).
  - 2 MODE: R/W.
  - 3 CTRL:
    - write: bit0 = GIE.
    - read: {iflag, 3'b0, GIE, ivect zero-extended to 3 bits}.
- Reset: IER=0, IPR=0, MODE=RST_MODE, GIE=0, irq_q=0, iflag=0, ivect=0. io_dout is combinational and therefore 0 whenever io_re is low.
- irq_q is irq registered once and is used for edge detection.
- Edge channel i (MODE[i]=1):
  - set: irq[i] & ~irq_q[i] sets IPR[i].
  - clear: ieack_stb with ieack==i, or a W1C write with bit i set.
  - set and clear in the same cycle: set wins, so no edge is lost.
  - the set happens regardless of IER[i]; masking only gates the request.
- Level channel i (MODE[i]=0):
  - IPR[i] <= irq[i] every cycle (a registered mirror).
  - W1C writes and acks have no lasting effect.
- Switching a channel from level to edge clears IPR[i] in the same cycle as the MODE write.
- Active vector: act = IPR & IER, masked to N_IRQ bits.
- Outputs, registered each cycle:
  - iflag <= GIE & |act.
  - ivect <= index of the lowest set bit of act; 0 if none.
- Latency:
  - edge channel: an irq rising edge at cycle t gives IPR set at t+1 and iflag/ivect at t+2.
  - level channel: same timing, because IPR is also a registered copy.
- Ack: the pending bit clears at t+1 after ieack_stb. iflag/ivect reflect the next-priority source at t+2.
- Ack for a non-pending or level channel, or for ieack >= N_IRQ: ignored.
- Register writes take effect the next cycle. A write to IER or GIE affects iflag with the same two-stage timing.
- Reads are side-effect free; io_dout is combinational from the current register values.
- rst asserted mid-operation: all state returns to reset values on the next edge. Pending edges are lost.

Decomposition:
- Shared package/header (sysdefs.h style) holds:
  - register offsets INTC_IER=0, INTC_IPR=1, INTC_MODE=2, INTC_CTRL=3;
  - CTRL bit positions GIE=0 and IFLAG=7.
- One sub-module: intc_prio_enc, a parametrised N_IRQ-in, VECT_WIDTH-out lowest-index-first encoder with an any-active output. It replaces the fixed 4-line encoder.

Test Plan:
1. Reset, then IER=0x0F, GIE=1, all channels in level mode.
   - Stimulus: hold irq=4'b0100.
   - Required: iflag=1, ivect=2 two cycles later. After irq drops, iflag=0 two cycles later.
2. MODE=0x0F; pulse irq[1] for one cycle.
   - Required: IPR reads 0x02 and iflag stays 1 with ivect=1 while irq[1] is low.
   - Then ieack_stb with ieack=1: IPR=0x00 and iflag=0 two cycles after the ack.
3. Edge mode. Pulse irq[3] and irq[0] together.
   - Required: ivect=0.
   - Ack 0: ivect=3 and iflag stays 1.
   - Ack 3: iflag=0.
4. Edge on irq[2] in the same cycle as a W1C write of 0x04 to IPR.
   - Required: IPR[2] stays 1 (set wins).
   - Then set IER=0x00: iflag=0 while IPR reads 0x04.
5. GIE=0 with a pending, enabled channel.
   - Required: iflag=0. CTRL read = 0x00 | ivect.
   - Write GIE=1: iflag=1 two cycles later. CTRL read has bit7=1 and bit3=1.
6. Pending edge on channel 1, then rst for one cycle.
   - Required: IPR=0, IER=0, iflag=0, and io_dout=0 with io_re low.
   - Also: ack with ieack=3 when N_IRQ=2 is ignored.

Source files
------------

// File: rtl/avr_io_intc_pkg.sv
// Shared definitions for the AVR I/O interrupt controller: register offsets
// on the I/O bus and bit positions inside the CTRL register.
package avr_io_intc_pkg;

   localparam logic [1:0] INTC_IER  = 2'd0;
   localparam logic [1:0] INTC_IPR  = 2'd1;
   localparam logic [1:0] INTC_MODE = 2'd2;
   localparam logic [1:0] INTC_CTRL = 2'd3;

   localparam int CTRL_GIE   = 0;
   localparam int CTRL_IFLAG = 7;

endpackage

// File: rtl/avr_io_intc_prio_enc.sv
// Lowest-index-first priority encoder: channel 0 always wins.
// idx_o is 0 when nothing is active.
module intc_prio_enc #(
   parameter int N_IRQ      = 4,
   parameter int VECT_WIDTH = 2
) (
   input  logic [N_IRQ-1:0]      req_i,
   output logic [VECT_WIDTH-1:0] idx_o,
   output logic                  any_o
);

   always_comb begin
      idx_o = '0;
      any_o = |req_i;
      // Scan from the top so the lowest set bit is the last one assigned.
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = VECT_WIDTH'(i);
      end
   end

endmodule

// File: rtl/avr_io_intc.sv
// Interrupt controller on the AVR I/O bus: per-channel enable and level/edge
// mode, global enable, and auto-clear of an edge pending bit on core ack.
module avr_io_intc
   import avr_io_intc_pkg::*;
#(
   parameter int         N_IRQ      = 4,
   parameter int         VECT_WIDTH = 2,
   parameter logic [7:0] RST_MODE   = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  io_re,
   input  logic                  io_we,
   input  logic [1:0]            io_a,
   input  logic [7:0]            io_do,
   output logic [7:0]            io_dout,
   input  logic [N_IRQ-1:0]      irq,
   input  logic                  ieack_stb,
   input  logic [VECT_WIDTH-1:0] ieack,
   output logic                  iflag,
   output logic [VECT_WIDTH-1:0] ivect
);

   logic [N_IRQ-1:0]      irq_q;
   logic [N_IRQ-1:0]      ier_q, ier_d;
   logic [N_IRQ-1:0]      ipr_q, ipr_d;
   logic [7:0]            mode_q, mode_d;
   logic                  gie_q, gie_d;
   logic                  iflag_q;
   logic [VECT_WIDTH-1:0] ivect_q;

   logic                  wr_ier, wr_ipr, wr_mode, wr_ctrl;
   logic [N_IRQ-1:0]      rise, w1c, ack_oh, to_edge, edge_mask, act;
   logic [VECT_WIDTH-1:0] enc_idx;
   logic                  enc_any;
   logic [2:0]            ivect3;

   assign wr_ier  = io_we && (io_a == INTC_IER);
   assign wr_ipr  = io_we && (io_a == INTC_IPR);
   assign wr_mode = io_we && (io_a == INTC_MODE);
   assign wr_ctrl = io_we && (io_a == INTC_CTRL);

   assign edge_mask = mode_q[N_IRQ-1:0];
   assign rise      = irq & ~irq_q;
   assign w1c       = wr_ipr ? io_do[N_IRQ-1:0] : '0;
   assign to_edge   = wr_mode ? (io_do[N_IRQ-1:0] & ~edge_mask) : '0;

   // ieack_stb is a single-cycle qualifier: ieack is only looked at while it is
   // high, there is no back-pressure, and vectors >= N_IRQ match no channel.
   always_comb begin
      ack_oh = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         ack_oh[i] = ieack_stb && (ieack == VECT_WIDTH'(i));
      end
   end

   // Edge channels: a new rising edge beats any clear in the same cycle.
   // Level channels: registered mirror of irq, zeroed on a switch to edge.
   always_comb begin
      ipr_d  = (edge_mask & (rise | (ipr_q & ~(w1c | ack_oh))))
             | (~edge_mask & irq & ~to_edge);
      ier_d  = wr_ier  ? io_do[N_IRQ-1:0] : ier_q;
      mode_d = wr_mode ? io_do : mode_q;
      gie_d  = wr_ctrl ? io_do[CTRL_GIE] : gie_q;
   end

   assign act = ipr_q & ier_q;

   intc_prio_enc #(
      .N_IRQ      (N_IRQ),
      .VECT_WIDTH (VECT_WIDTH)
   ) u_prio_enc (
      .req_i (act),
      .idx_o (enc_idx),
      .any_o (enc_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q   <= '0;
         ier_q   <= '0;
         ipr_q   <= '0;
         mode_q  <= RST_MODE;
         gie_q   <= 1'b0;
         iflag_q <= 1'b0;
         ivect_q <= '0;
      end else begin
         irq_q   <= irq;
         ier_q   <= ier_d;
         ipr_q   <= ipr_d;
         mode_q  <= mode_d;
         gie_q   <= gie_d;
         iflag_q <= gie_q & enc_any;
         ivect_q <= enc_idx;
      end
   end

   assign iflag  = iflag_q;
   assign ivect  = ivect_q;
   assign ivect3 = 3'(ivect_q);

   // Read mux drives 0 when not selected so several peripherals can be OR-ed.
   always_comb begin
      io_dout = '0;
      if (io_re) begin
         case (io_a)
            INTC_IER:  io_dout = 8'(ier_q);
            INTC_IPR:  io_dout = 8'(ipr_q);
            INTC_MODE: io_dout = mode_q;
            default:   io_dout = {iflag_q, 3'b000, gie_q, ivect3};
         endcase
      end
   end

endmodule
